idex_hazard_reg: RTL
====================

Name: idex_hazard_reg

Overview:
- ID/EX pipeline register combined with the hazard detection unit; it sits directly upstream of the forwarding unit and drives its ID_EX_RegisterRs1/Rs2 inputs.
- Forwarding exists only from MEM/WB, so any register-writing instruction in EX with a dependent instruction in ID causes a one-cycle stall. The stall is implemented as a bubble into ID/EX while PC and IF/ID are held.
- A branch-taken flush from EX/MEM clears the register.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_id_rs1  in  5  source register 1 of the instruction in ID.
- if_id_rs2  in  5  source register 2 of the instruction in ID.
- id_uses_rs1  in  1  instruction in ID reads rs1.
- id_uses_rs2  in  1  instruction in ID reads rs2.
- id_rd  in  5  destination register of the instruction in ID.
- id_ctrl  in  8  {Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}.
- id_rs1_data  in  XLEN  register-file read data 1.
- id_rs2_data  in  XLEN  register-file read data 2.
- id_imm  in  XLEN  immediate.
- id_pc  in  XLEN  PC of the instruction in ID.
- id_funct  in  4  {funct7[5], funct3}.
- flush  in  1  branch taken, from EX/MEM.
- stall  out  1  hold PC and IF/ID (both write enables low).
- ID_EX_RegisterRs1  out  5  registered rs1.
- ID_EX_RegisterRs2  out  5  registered rs2.
- ID_EX_rd  out  5  registered rd.
- ID_EX_ctrl  out  8  registered control bundle.
- ID_EX_rs1_data  out  XLEN  registered read data 1.
- ID_EX_rs2_data  out  XLEN  registered read data 2.
- ID_EX_imm  out  XLEN  registered immediate.
- ID_EX_pc  out  XLEN  registered PC.
- ID_EX_funct  out  4  registered funct bits.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): every ID_EX_* output and stall_count go to 0. A zero ctrl word is a NOP bubble.
- Hazard (combinational):
  - haz = ID_EX_ctrl.RegWrite && ID_EX_rd!=0 && ((id_uses_rs1 && ID_EX_rd==if_id_rs1) || (id_uses_rs2 && ID_EX_rd==if_id_rs2)).
  - stall = haz && !flush.
- Register update on each rising clk, in priority order:
  1. flush=1: all ID_EX_* fields load 0 (bubble). Flush wins over the hazard.
  2. stall=1: ID_EX_ctrl, ID_EX_rd, ID_EX_RegisterRs1 and ID_EX_RegisterRs2 load 0 (bubble). Data fields may load or hold; their value is don't-care.
  3. Otherwise: all fields load the corresponding id_* inputs. The register-source fields load if_id_rs1/if_id_rs2, forced to 0 when the matching id_uses_* is 0, so the forwarding unit never matches an unused operand.
- Stall length is exactly one cycle. The next cycle ID/EX holds the bubble, the producer is in EX/MEM, haz=0 and the consumer advances. The consumer reaches EX when the producer is in MEM/WB, and the forwarding unit supplies the value.
- A producer two stages ahead needs no stall (forwarded from MEM/WB).
- A producer three stages ahead needs no stall. The register file is write-first (half-cycle write), system fact.
- rd=x0 never stalls.
- A load followed by a dependent instruction is handled by the same single stall as an ALU producer.
- Back-to-back dependents on one producer: only the first one stalls.
- stall_count increments by 1 on each clock where stall=1 and saturates at all-ones (no wrap).
- Reset asserted mid-operation clears all state immediately. The first cycle after reset deassertion has no hazard, since ID_EX_ctrl=0.

Decomposition:
- Shared package/header holds:
  - ctrl bundle field bit positions (CTRL_BRANCH=7 … CTRL_REGWRITE=0).
  - CTRL_W=8, REG_W=5.
  - the NOP ctrl constant 8'h00.
- Natural sub-module: hazard_detect, the combinational haz equation. It is reusable if EX/MEM forwarding is added later.
- Registers and counter stay in the top module.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 (uses rs1) -> stall=1 for exactly one cycle; bubble ctrl=0 enters ID/EX; the sub enters EX with ID_EX_RegisterRs1=5; stall_count=1.
- lw x7,0(x1) then add x8,x2,x7 -> one stall on the rs2 match; next cycle ID_EX_RegisterRs2=7 while the load's MEMWB_rd=7.
- addi x0,x0,1 then add x9,x0,x0 -> stall=0; rd=0 suppresses the hazard.
- Hazard and flush in the same cycle -> stall=0; after the edge all ID_EX_* fields=0; stall_count unchanged.
- add x5,… then lui x5,… (id_uses_rs1=0, id_uses_rs2=0, if_id_rs1=5) -> stall=0; ID_EX_RegisterRs1=0.
- Force 2^CNT_W+3 stall cycles, then pulse rst=0 asynchronously between clock edges -> stall_count holds at 16'hFFFF, then immediately reads 0 and all outputs read 0 without waiting for a clk edge.

Source files
------------

// File: rtl/idex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX register and hazard unit: ctrl bundle layout, widths, NOP word.
// Constants only; no logic.
package idex_hazard_reg_pkg;
    localparam int CTRL_W = 8;
    localparam int REG_W  = 5;

    localparam int CTRL_BRANCH   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUOP_HI = 4;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGWRITE = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;
endpackage

// File: rtl/idex_hazard_reg_hazard_detect.sv
// Combinational RAW hazard check between the instruction in EX and the one in ID.
// Zero latency; no backpressure of its own.
module idex_hazard_reg_hazard_detect
    import idex_hazard_reg_pkg::*;
(
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    output logic             haz
);
    logic match1;
    logic match2;

    assign match1 = uses_rs1 && (ex_rd == rs1);
    assign match2 = uses_rs2 && (ex_rd == rs2);
    // x0 is hardwired zero, so a write to it can never create a dependency
    assign haz    = ex_regwrite && (ex_rd != '0) && (match1 || match2);
endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with hazard stall generation and a saturating stall counter.
// One-cycle register; on stall a bubble enters ID/EX while PC and IF/ID hold; flush clears everything.
module idex_hazard_reg
    import idex_hazard_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  if_id_rs1,
    input  logic [REG_W-1:0]  if_id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [3:0]        id_funct,
    input  logic              flush,
    output logic              stall,
    output logic [REG_W-1:0]  ID_EX_RegisterRs1,
    output logic [REG_W-1:0]  ID_EX_RegisterRs2,
    output logic [REG_W-1:0]  ID_EX_rd,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [3:0]        ID_EX_funct,
    output logic [CNT_W-1:0]  stall_count
);
    logic haz;

    idex_hazard_reg_hazard_detect u_hazard_detect (
        .ex_regwrite (ID_EX_ctrl[CTRL_REGWRITE]),
        .ex_rd       (ID_EX_rd),
        .rs1         (if_id_rs1),
        .rs2         (if_id_rs2),
        .uses_rs1    (id_uses_rs1),
        .uses_rs2    (id_uses_rs2),
        .haz         (haz)
    );

    // A taken branch kills the ID instruction anyway, so stalling it is pointless
    assign stall = haz && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ID_EX_RegisterRs1 <= '0;
            ID_EX_RegisterRs2 <= '0;
            ID_EX_rd          <= '0;
            ID_EX_ctrl        <= CTRL_NOP;
            ID_EX_rs1_data    <= '0;
            ID_EX_rs2_data    <= '0;
            ID_EX_imm         <= '0;
            ID_EX_pc          <= '0;
            ID_EX_funct       <= '0;
            stall_count       <= '0;
        end else begin
            if (flush) begin
                ID_EX_RegisterRs1 <= '0;
                ID_EX_RegisterRs2 <= '0;
                ID_EX_rd          <= '0;
                ID_EX_ctrl        <= CTRL_NOP;
                ID_EX_rs1_data    <= '0;
                ID_EX_rs2_data    <= '0;
                ID_EX_imm         <= '0;
                ID_EX_pc          <= '0;
                ID_EX_funct       <= '0;
            end else begin
                // Data fields of a bubble are never consumed, so they simply follow ID
                ID_EX_rs1_data <= id_rs1_data;
                ID_EX_rs2_data <= id_rs2_data;
                ID_EX_imm      <= id_imm;
                ID_EX_pc       <= id_pc;
                ID_EX_funct    <= id_funct;
                if (stall) begin
                    ID_EX_RegisterRs1 <= '0;
                    ID_EX_RegisterRs2 <= '0;
                    ID_EX_rd          <= '0;
                    ID_EX_ctrl        <= CTRL_NOP;
                end else begin
                    // Unused operands read as x0 so forwarding never matches them
                    ID_EX_RegisterRs1 <= id_uses_rs1 ? if_id_rs1 : '0;
                    ID_EX_RegisterRs2 <= id_uses_rs2 ? if_id_rs2 : '0;
                    ID_EX_rd          <= id_rd;
                    ID_EX_ctrl        <= id_ctrl;
                end
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
endmodule
